// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the divide sequencer and its helpers.
//   ST_*      : 3-bit sequencer state encodings
//   NBIT_DEF  : default operand/result width, shared with the divider instance
package div_seq_ctrl_pkg;

  localparam int unsigned NBIT_DEF = 32;

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] ST_IDLE = 3'd0;
  localparam logic [StateW-1:0] ST_LOAD = 3'd1;
  localparam logic [StateW-1:0] ST_RUN  = 3'd2;
  localparam logic [StateW-1:0] ST_FIX  = 3'd3;
  localparam logic [StateW-1:0] ST_ZERO = 3'd4;

endpackage

// File: rtl/div_seq_ctrl_sign_fix.sv
// Combinational conditional two's-complement negate.
// Used both for operand magnitudes and for quotient/remainder sign fixup.
//   val_i : input value
//   neg_i : 1 = return -val_i (NBit wrap), 0 = pass through
//   res_c : result (combinational)
module div_sign_fix
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned NBit = NBIT_DEF
) (
  input  logic [NBit-1:0] val_i,
  input  logic            neg_i,
  output logic [NBit-1:0] res_c
);

  assign res_c = neg_i ? ((~val_i) + NBit'(1)) : val_i;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer and HI/LO owner for the iterative restoring divider.
// Inputs : Clk, Reset (async, active-high), Start/Signed/OpA/OpB (divide issue),
//          MthiEn/MtloEn/WrData (HI/LO writes), HiLoRead, Cancel,
//          DivQuot/DivRem/DivDone (divider results).
// Outputs: Hi, Lo, Busy, Stall (combinational), DivZero pulse,
//          DivWork/DivDividend/DivDivisor (divider control).
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned NBit = NBIT_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Signed,
  input  logic [NBit-1:0] OpA,
  input  logic [NBit-1:0] OpB,
  input  logic            MthiEn,
  input  logic            MtloEn,
  input  logic [NBit-1:0] WrData,
  input  logic            HiLoRead,
  input  logic            Cancel,
  output logic [NBit-1:0] Hi,
  output logic [NBit-1:0] Lo,
  output logic            Busy,
  output logic            Stall,
  output logic            DivZero,
  output logic            DivWork,
  output logic [NBit-1:0] DivDividend,
  output logic [NBit-1:0] DivDivisor,
  input  logic [NBit-1:0] DivQuot,
  input  logic [NBit-1:0] DivRem,
  input  logic            DivDone
);

  logic [StateW-1:0] state_q, state_d;
  logic [NBit-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [NBit-1:0]   dividend_q, dividend_d, divisor_q, divisor_d;
  logic [NBit-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic              busy_q, busy_d, work_q, work_d, zero_q, zero_d;

  logic [NBit-1:0]   abs_a_c, abs_b_c, fix_quot_c, fix_rem_c;

  // Operand magnitudes: negate only for a signed divide with a negative operand.
  div_sign_fix #(.NBit(NBit)) u_abs_a (
    .val_i(OpA), .neg_i(Signed & OpA[NBit-1]), .res_c(abs_a_c)
  );
  div_sign_fix #(.NBit(NBit)) u_abs_b (
    .val_i(OpB), .neg_i(Signed & OpB[NBit-1]), .res_c(abs_b_c)
  );

  // Result sign fixup from the flags latched at issue.
  div_sign_fix #(.NBit(NBit)) u_fix_q (
    .val_i(quot_q), .neg_i(qneg_q), .res_c(fix_quot_c)
  );
  div_sign_fix #(.NBit(NBit)) u_fix_r (
    .val_i(rem_q), .neg_i(rneg_q), .res_c(fix_rem_c)
  );

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      busy_q     <= 1'b0;
      work_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      busy_q     <= busy_d;
      work_q     <= work_d;
      zero_q     <= zero_d;
    end
  end

  // Next-state and next-output logic; Cancel overrides everything.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    zero_d     = 1'b0;

    if (Cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            dividend_d = abs_a_c;
            divisor_d  = abs_b_c;
            qneg_d     = Signed & (OpA[NBit-1] ^ OpB[NBit-1]);
            rneg_d     = Signed & OpA[NBit-1];
            state_d    = (OpB == '0) ? ST_ZERO : ST_LOAD;
          end else begin
            if (MthiEn) hi_d = WrData;
            if (MtloEn) lo_d = WrData;
          end
        end
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (DivDone) begin
            quot_d  = DivQuot;
            rem_d   = DivRem;
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          lo_d    = fix_quot_c;
          hi_d    = fix_rem_c;
          state_d = ST_IDLE;
        end
        ST_ZERO: begin
          lo_d    = '0;
          hi_d    = '0;
          zero_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    work_d = (state_d == ST_RUN);
  end

  assign Hi          = hi_q;
  assign Lo          = lo_q;
  assign Busy        = busy_q;
  assign DivZero     = zero_q;
  assign DivWork     = work_q;
  assign DivDividend = dividend_q;
  assign DivDivisor  = divisor_q;

  // Stall any HI/LO access or new issue while a divide is in flight.
  assign Stall = busy_q & (Start | HiLoRead | MthiEn | MtloEn);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl with a behavioural divider.
module tb_div_seq_ctrl;

  localparam int unsigned NBit = 32;
  localparam int unsigned Lat  = 34;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start, Signed, MthiEn, MtloEn, HiLoRead, Cancel;
  logic [NBit-1:0] OpA, OpB, WrData;
  logic [NBit-1:0] Hi, Lo, DivDividend, DivDivisor, DivQuot, DivRem;
  logic            Busy, Stall, DivZero, DivWork, DivDone;

  int n_tests = 0;
  int n_fail  = 0;
  int div_cnt;
  logic work_seen;
  logic last_work;

  div_seq_ctrl #(.NBit(NBit)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(Signed), .OpA(OpA), .OpB(OpB),
    .MthiEn(MthiEn), .MtloEn(MtloEn), .WrData(WrData), .HiLoRead(HiLoRead),
    .Cancel(Cancel), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Stall(Stall), .DivZero(DivZero),
    .DivWork(DivWork), .DivDividend(DivDividend), .DivDivisor(DivDivisor),
    .DivQuot(DivQuot), .DivRem(DivRem), .DivDone(DivDone)
  );

  always #5 Clk = ~Clk;

  // Behavioural divider: Done after Lat cycles of Work, cleared when Work drops.
  assign DivQuot = (DivDivisor != '0) ? DivDividend / DivDivisor : '1;
  assign DivRem  = (DivDivisor != '0) ? DivDividend % DivDivisor : DivDividend;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= 0;
      DivDone <= 1'b0;
    end else if (!DivWork) begin
      div_cnt <= 0;
      DivDone <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1;
      if (div_cnt == Lat - 1) DivDone <= 1'b1;
    end
  end

  always @(posedge Clk) if (DivWork) work_seen <= 1'b1;

  task automatic chk(input string tag, input logic [NBit-1:0] got, input logic [NBit-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic sgn, input logic [NBit-1:0] a, input logic [NBit-1:0] b);
    Start = 1'b1; Signed = sgn; OpA = a; OpB = b;
    tick();
    Start = 1'b0; Signed = 1'b0; OpA = '0; OpB = '0;
  endtask

  // Run until Busy drops; remembers DivWork of the last busy cycle.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (Busy && n < 200) begin
      last_work = DivWork;
      tick();
      n++;
    end
    if (Busy) chk({tag, "_timeout"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Signed = 1'b0; OpA = '0; OpB = '0;
    MthiEn = 1'b0; MtloEn = 1'b0; WrData = '0; HiLoRead = 1'b0; Cancel = 1'b0;
    work_seen = 1'b0; last_work = 1'b0;
    #12;
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_work", 32'(DivWork), 32'd0);
    chk("rst_dvd", DivDividend, 32'd0);
    tick();
    Reset = 1'b0;
    tick();

    // DIVU 100/7
    issue(1'b0, 32'd100, 32'd7);
    chk("u_load_busy", 32'(Busy), 32'd1);
    chk("u_load_work", 32'(DivWork), 32'd0);
    chk("u_load_dvd", DivDividend, 32'd100);
    chk("u_load_dvs", DivDivisor, 32'd7);
    tick();
    chk("u_run_work", 32'(DivWork), 32'd1);
    wait_idle("u");
    chk("u_fix_work", 32'(last_work), 32'd0);
    chk("u_lo", Lo, 32'd14);
    chk("u_hi", Hi, 32'd2);

    // DIV -7/2 and 7/-2
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("s1_dvd", DivDividend, 32'd7);
    wait_idle("s1");
    chk("s1_lo", Lo, 32'hFFFF_FFFD);
    chk("s1_hi", Hi, 32'hFFFF_FFFF);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);
    chk("s2_dvs", DivDivisor, 32'd2);
    wait_idle("s2");
    chk("s2_lo", Lo, 32'hFFFF_FFFD);
    chk("s2_hi", Hi, 32'd1);

    // Signed overflow MIN / -1
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("ov");
    chk("ov_lo", Lo, 32'h8000_0000);
    chk("ov_hi", Hi, 32'd0);

    // DIVU 5/0: one busy cycle, DivZero pulse after commit, Work never raised
    MthiEn = 1'b1; WrData = 32'h0000_00AA;
    tick();
    MthiEn = 1'b0;
    chk("mthi", Hi, 32'h0000_00AA);
    work_seen = 1'b0;
    issue(1'b0, 32'd5, 32'd0);
    chk("z_busy1", 32'(Busy), 32'd1);
    chk("z_work", 32'(DivWork), 32'd0);
    chk("z_nopulse_yet", 32'(DivZero), 32'd0);
    tick();
    chk("z_busy2", 32'(Busy), 32'd0);
    chk("z_pulse", 32'(DivZero), 32'd1);
    chk("z_lo", Lo, 32'd0);
    chk("z_hi", Hi, 32'd0);
    tick();
    chk("z_pulse_end", 32'(DivZero), 32'd0);
    chk("z_work_never", 32'(work_seen), 32'd0);

    // Stall on HI/LO access mid-RUN; Mt* ignored while busy
    MthiEn = 1'b1; MtloEn = 1'b1; WrData = 32'h0000_5555;
    tick();
    MthiEn = 1'b0; MtloEn = 1'b0;
    chk("mt_lo", Lo, 32'h0000_5555);
    chk("idle_stall", 32'(Stall), 32'd0);
    issue(1'b0, 32'd100, 32'd7);
    tick(); tick(); tick();
    HiLoRead = 1'b1;
    #1;
    chk("st_read", 32'(Stall), 32'd1);
    HiLoRead = 1'b0; MtloEn = 1'b1; WrData = 32'h0000_9999;
    #1;
    chk("st_mtlo", 32'(Stall), 32'd1);
    tick();
    MtloEn = 1'b0;
    #1;
    chk("st_none", 32'(Stall), 32'd0);
    chk("st_lo_hold", Lo, 32'h0000_5555);
    chk("st_hi_hold", Hi, 32'h0000_5555);
    wait_idle("st");
    chk("st_lo", Lo, 32'd14);
    chk("st_hi", Hi, 32'd2);
    MtloEn = 1'b1; WrData = 32'h0000_1234;
    tick();
    MtloEn = 1'b0;
    chk("mtlo_lo", Lo, 32'h0000_1234);
    chk("mtlo_hi", Hi, 32'd2);

    // Cancel 10 cycles into RUN
    issue(1'b0, 32'd100, 32'd7);
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("c_in_run", 32'(DivWork), 32'd1);
    Cancel = 1'b1;
    tick();
    Cancel = 1'b0;
    chk("c_work", 32'(DivWork), 32'd0);
    chk("c_busy", 32'(Busy), 32'd0);
    chk("c_lo", Lo, 32'h0000_1234);
    chk("c_hi", Hi, 32'd2);

    // Cancel wins over Start in the same cycle
    Cancel = 1'b1;
    issue(1'b0, 32'd9, 32'd3);
    Cancel = 1'b0;
    chk("cs_busy", 32'(Busy), 32'd0);

    // Start 3/1 then back-to-back 9/2
    issue(1'b0, 32'd3, 32'd1);
    wait_idle("b1");
    chk("b1_lo", Lo, 32'd3);
    chk("b1_hi", Hi, 32'd0);
    chk("b_gap_work", 32'(DivWork), 32'd0);
    issue(1'b0, 32'd9, 32'd2);
    chk("b2_load_work", 32'(DivWork), 32'd0);
    wait_idle("b2");
    chk("b2_lo", Lo, 32'd4);
    chk("b2_hi", Hi, 32'd1);

    // Reset mid-RUN
    issue(1'b1, 32'hFFFF_FF9C, 32'd7);
    tick(); tick(); tick();
    HiLoRead = 1'b1;
    Reset = 1'b1;
    #1;
    chk("r_busy", 32'(Busy), 32'd0);
    chk("r_work", 32'(DivWork), 32'd0);
    chk("r_stall", 32'(Stall), 32'd0);
    chk("r_lo", Lo, 32'd0);
    chk("r_hi", Hi, 32'd0);
    chk("r_dvd", DivDividend, 32'd0);
    chk("r_dvs", DivDivisor, 32'd0);
    chk("r_zero", 32'(DivZero), 32'd0);
    HiLoRead = 1'b0;
    tick();
    Reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Sequencer and HI/LO owner for the CPU's iterative restoring divider (Work/Done level handshake, quotient/remainder outputs).
- Accepts DIV/DIVU issue from the EX stage and converts signed operands to magnitudes.
- Drives the divider through a clean load/run/release sequence, sign-corrects the results and commits them to HI/LO.
- Also services MTHI/MTLO writes and raises a pipeline stall for any HI/LO access while a divide is in flight.

Parameters:
NBit, 32, operand/result width; must match the divider instance.

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  issue DIV/DIVU this cycle (1-cycle pulse from EX)
Signed  in  1  1=DIV, 0=DIVU; sampled with Start
OpA  in  NBit  dividend (rs); sampled with Start
OpB  in  NBit  divisor (rt); sampled with Start
MthiEn  in  1  write WrData to HI
MtloEn  in  1  write WrData to LO
WrData  in  NBit  MTHI/MTLO data
HiLoRead  in  1  MFHI/MFLO in EX this cycle
Cancel  in  1  exception flush; abort any divide in flight
Hi  out  NBit  HI register
Lo  out  NBit  LO register
Busy  out  1  divide in flight
Stall  out  1  pipeline stall request
DivZero  out  1  1-cycle pulse on commit of a zero-divisor divide
DivWork  out  1  divider Work
DivDividend  out  NBit  divider dividend (magnitude)
DivDivisor  out  NBit  divider divisor (magnitude)
DivQuot  in  NBit  divider quotient
DivRem  in  NBit  divider remainder
DivDone  in  1  divider Done

Behaviour:
- Reset values:
  - Hi=Lo=0, Busy=0, Stall=0, DivZero=0, DivWork=0
  - DivDividend=DivDivisor=0
  - state=IDLE, sign flags cleared
- IDLE:
  - Start && !Cancel: latch |OpA|, |OpB|. Magnitude = two's-complement negate only if Signed and MSB=1.
  - Latch qneg = Signed & (OpA[msb]^OpB[msb]) and rneg = Signed & OpA[msb].
  - If OpB==0 go to ZERO, else go to LOAD.
- LOAD (1 cycle):
  - DivWork=0 with operands stable, so the divider loads the dividend.
  - Next state RUN.
- RUN:
  - DivWork=1, operands held constant.
  - Stay until DivDone=1 is sampled; then capture DivQuot/DivRem into internal regs and go to FIX.
  - The controller makes no assumption about divider latency (nominally NBit+2 cycles of Work).
- FIX (1 cycle):
  - DivWork=0.
  - Lo <= qneg ? -quot : quot; Hi <= rneg ? -rem : rem (NBit-bit wrap arithmetic).
  - Next state IDLE.
- ZERO (1 cycle):
  - Lo<=0, Hi<=0, DivZero=1, DivWork stays 0.
  - Next state IDLE.
- Busy:
  - High in LOAD/RUN/FIX/ZERO, low in IDLE.
  - HI/LO become visible the cycle after FIX/ZERO.
- Stall = Busy & (Start | HiLoRead | MthiEn | MtloEn).
  - Start/MTHI/MTLO while Busy are ignored; the issuer holds them under Stall.
- MthiEn/MtloEn in IDLE (no Start that cycle): Hi/Lo <= WrData next edge.
  - Start plus Mt*En in the same cycle is illegal.
- Cancel:
  - Any state: next state IDLE, DivWork=0, HI/LO unchanged, DivZero suppressed.
  - Cancel and Start in the same cycle: Cancel wins.
- Overflow: signed MIN / -1 yields Lo=MIN, Hi=0. No trap.
- DivWork is guaranteed low for at least 1 cycle between consecutive divides, which re-arms the divider.
- Reset mid-operation returns everything to reset values immediately; the divider is reset on the same net.

Decomposition:
- Shared package holds:
  - state encodings IDLE/LOAD/RUN/FIX/ZERO as 3-bit localparams
  - an NBit default constant shared with the divider
- One natural sub-module: div_sign_fix. It is combinational magnitude/negate logic reused for operand abs and result fixup.

Test Plan:
- DIVU 100/7 → after DivDone and FIX: Lo=14, Hi=2; Busy high from cycle after Start to FIX inclusive.
- DIV -7/2 (0xFFFFFFF9/2) → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 7/-2 → Lo=0xFFFFFFFD, Hi=1.
- DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0; DIVU 5/0 → Lo=Hi=0, DivZero pulse, Busy exactly 1 cycle, DivWork never high.
- HiLoRead and MtloEn asserted mid-RUN → Stall=1 and HI/LO unchanged until after FIX; then MTLO 0x1234 in IDLE → Lo=0x1234 next cycle.
- Cancel asserted 10 cycles into RUN → DivWork=0 next cycle, state IDLE, HI/LO keep prior values; next Start 3/1 completes with Lo=3, Hi=0.
- Back-to-back Starts → DivWork low ≥1 cycle between ops; Reset mid-RUN → all outputs at reset values, Busy=0.
